clock_mode_ctrl: RTL

User-interface sequencer for the digital clock. It takes three raw push-buttons and runs a mode state machine that selects what is being edited: running time, time hours/minutes, or alarm hours/minutes. It emits single-cycle increment strobes to the timekeeping counters and the alarm-setpoint registers, drives the mode LEDs, and lets the user mute a ringing alarm. It sits between the board buttons and the time/alarm datapath and is the only source of their increment enables.

---
 rtl/clock_pkg.sv | 24 ++
 rtl/btn_sync_edge.sv | 37 +++
 rtl/clock_mode_ctrl.sv | 135 +++++++++++++
 3 files changed

// File: rtl/clock_pkg.sv
// Shared types and constants for the clock user-interface sequencer.
package clock_pkg;

  typedef enum logic [2:0] {
    RUN   = 3'd0,
    T_HR  = 3'd1,
    T_MIN = 3'd2,
    A_HR  = 3'd3,
    A_MIN = 3'd4
  } mode_t;

  localparam logic [4:0] IDLE_TIMEOUT  = 5'd31;
  localparam logic [3:0] REPEAT_DELAY  = 4'd8;
  localparam logic [3:0] REPEAT_PERIOD = 4'd2;

  function automatic logic is_edit(mode_t m);
    return (m == T_HR) || (m == T_MIN) || (m == A_HR) || (m == A_MIN);
  endfunction

  function automatic logic is_time_edit(mode_t m);
    return (m == T_HR) || (m == T_MIN);
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer plus registered rising-edge detector for one push-button.
module btn_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level,
  output logic press
);

  logic meta_p0, sync_p1, prev_p2;
  logic vld_p0, vld_p1, vld_p2;

  // vld_pN marks stages holding real samples, so a button held through
  // reset release never looks like a fresh 0->1 edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      prev_p2 <= 1'b0;
      vld_p0  <= 1'b0;
      vld_p1  <= 1'b0;
      vld_p2  <= 1'b0;
      press   <= 1'b0;
    end else begin
      meta_p0 <= btn;
      vld_p0  <= 1'b1;
      sync_p1 <= meta_p0;
      vld_p1  <= vld_p0;
      prev_p2 <= sync_p1;
      vld_p2  <= vld_p1;
      press   <= sync_p1 & ~prev_p2 & vld_p2;
    end
  end

  assign level = sync_p1;

endmodule

// File: rtl/clock_mode_ctrl.sv
// Mode sequencer for the digital clock: buttons in, edit strobes/LEDs/mute out.
// Optional hold-to-repeat on the inc button is built when CLOCK_AUTO_REPEAT_EN is defined.
module clock_mode_ctrl
  import clock_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       btn_mode,
  input  logic       btn_sel,
  input  logic       btn_inc,
  input  logic       alarm_ring,
  output logic       inc_time_hr,
  output logic       inc_time_min,
  output logic       inc_alarm_hr,
  output logic       inc_alarm_min,
  output logic       clr_time_sec,
  output logic [2:0] mode,
  output logic       LED_hr,
  output logic       LED_min,
  output logic       LED_alarm,
  output logic       alarm_mute
);

  logic       lvl_mode, lvl_sel, lvl_inc;
  logic       prs_mode, prs_sel, prs_inc;
  logic       any_press, edit, repeat_stb;
  logic       unused_lvl;
  mode_t      state, state_nxt;
  logic [4:0] idle_cnt, idle_nxt;
  logic [3:0] inc_nxt;
  logic [2:0] led_nxt;
  logic       clr_nxt, mute_set, mute_nxt;

  btn_sync_edge u_mode (.clk(clk), .rst(rst), .btn(btn_mode), .level(lvl_mode), .press(prs_mode));
  btn_sync_edge u_sel  (.clk(clk), .rst(rst), .btn(btn_sel),  .level(lvl_sel),  .press(prs_sel));
  btn_sync_edge u_inc  (.clk(clk), .rst(rst), .btn(btn_inc),  .level(lvl_inc),  .press(prs_inc));

  assign unused_lvl = lvl_mode ^ lvl_sel ^ lvl_inc;
  assign any_press  = prs_mode | prs_sel | prs_inc;
  assign edit       = is_edit(state);
  assign mode       = state;

`ifdef CLOCK_AUTO_REPEAT_EN
  logic [3:0] hold_cnt, hold_nxt;

  // Past the top the counter steps back by one period so its phase is kept.
  always_comb begin
    hold_nxt   = hold_cnt;
    repeat_stb = 1'b0;
    if (!edit || !lvl_inc || prs_mode || prs_sel) begin
      hold_nxt = '0;
    end else if (tick) begin
      hold_nxt   = (hold_cnt == 4'hF) ? (4'hF - REPEAT_PERIOD + 4'd1) : (hold_cnt + 4'd1);
      repeat_stb = (hold_nxt >= REPEAT_DELAY) &&
                   (((hold_nxt - REPEAT_DELAY) % REPEAT_PERIOD) == 4'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) hold_cnt <= '0;
    else     hold_cnt <= hold_nxt;
  end
`else
  assign repeat_stb = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= RUN;
      idle_cnt      <= '0;
      inc_time_hr   <= 1'b0;
      inc_time_min  <= 1'b0;
      inc_alarm_hr  <= 1'b0;
      inc_alarm_min <= 1'b0;
      clr_time_sec  <= 1'b0;
      LED_hr        <= 1'b0;
      LED_min       <= 1'b0;
      LED_alarm     <= 1'b0;
      alarm_mute    <= 1'b0;
    end else begin
      state         <= state_nxt;
      idle_cnt      <= idle_nxt;
      {inc_time_hr, inc_time_min, inc_alarm_hr, inc_alarm_min} <= inc_nxt;
      clr_time_sec  <= clr_nxt;
      {LED_hr, LED_min, LED_alarm} <= led_nxt;
      alarm_mute    <= mute_nxt;
    end
  end

  // Press priority mode > sel > inc; a timeout only fires on an otherwise quiet tick.
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:         if (prs_mode) state_nxt = T_HR;
      T_HR, T_MIN: begin
        if (prs_mode)     state_nxt = A_HR;
        else if (prs_sel) state_nxt = (state == T_HR) ? T_MIN : T_HR;
      end
      A_HR, A_MIN: begin
        if (prs_mode)     state_nxt = RUN;
        else if (prs_sel) state_nxt = (state == A_HR) ? A_MIN : A_HR;
      end
      default:     state_nxt = RUN;
    endcase
    if (edit && !any_press && !repeat_stb && tick && (idle_cnt == IDLE_TIMEOUT))
      state_nxt = RUN;
  end

  always_comb begin
    if (!edit || any_press || repeat_stb) idle_nxt = '0;
    else if (tick)                        idle_nxt = (idle_cnt == IDLE_TIMEOUT) ? 5'd0 : (idle_cnt + 5'd1);
    else                                  idle_nxt = idle_cnt;
  end

  always_comb begin
    inc_nxt = '0;
    if (edit && !prs_mode && !prs_sel && (prs_inc || repeat_stb)) begin
      case (state)
        T_HR:    inc_nxt = 4'b1000;
        T_MIN:   inc_nxt = 4'b0100;
        A_HR:    inc_nxt = 4'b0010;
        A_MIN:   inc_nxt = 4'b0001;
        default: inc_nxt = 4'b0000;
      endcase
    end
    clr_nxt  = is_time_edit(state) && ((state_nxt == A_HR) || (state_nxt == RUN));
    mute_set = (state == RUN) && prs_sel && !prs_mode && alarm_ring;
    mute_nxt = alarm_ring && (alarm_mute || mute_set);
    led_nxt  = {(state_nxt == T_HR)  || (state_nxt == A_HR),
                (state_nxt == T_MIN) || (state_nxt == A_MIN),
                (state_nxt == A_HR)  || (state_nxt == A_MIN)};
  end

endmodule
